// File: rtl/obstacle_painter.sv
// Rectangle raster engine for the 160x120x3 image memory: one pixel write per clock, busy/done handshake.
// Optional border-only painting is enabled by defining OBSTACLE_OUTLINE_EN.
module obstacle_painter #(
  parameter logic [7:0] XMAX = 8'd159,
  parameter logic [6:0] YMAX = 7'd119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [2:0] color,
  input  logic       outline,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_write,
  output logic [6:0] y_write,
  output logic [2:0] color_in,
  output logic       wren
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, FIN} state_t;

  state_t     state, state_n;
  logic [7:0] lx0, lx1, cx, cx_n;
  logic [6:0] ly0, ly1, cy, cy_n;
  logic [2:0] lcol;
  logic       busy_n, done_n, wren_n, accept;
  logic [7:0] xl, xh_raw, xh;
  logic [6:0] yl, yh_raw, yh;

`ifdef OBSTACLE_OUTLINE_EN
  logic lout;
`else
  logic unused_outline;
  assign unused_outline = outline;
`endif

  // Bounds are derived from the latched corners every cycle rather than stored.
  assign xl     = (lx0 < lx1) ? lx0 : lx1;
  assign xh_raw = (lx0 < lx1) ? lx1 : lx0;
  assign xh     = (xh_raw > XMAX) ? XMAX : xh_raw;
  assign yl     = (ly0 < ly1) ? ly0 : ly1;
  assign yh_raw = (ly0 < ly1) ? ly1 : ly0;
  assign yh     = (yh_raw > YMAX) ? YMAX : yh_raw;

  assign accept = (state == IDLE) && start;

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    busy_n  = busy;
    done_n  = 1'b0;
    wren_n  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        busy_n  = 1'b1;
      end
      LOAD: if (xl > XMAX || yl > YMAX) begin
        state_n = FIN;
        done_n  = 1'b1;
      end else begin
        state_n = FILL;
        cx_n    = xl;
        cy_n    = yl;
      end
      FILL: if (cx == xh && cy == yh) begin
        state_n = FIN;
        done_n  = 1'b1;
      end else if (cx == xh) begin
        cx_n = xl;
        cy_n = cy + 7'd1;
      end else begin
        cx_n = cx + 8'd1;
      end
      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    // Strobe is registered alongside the address it qualifies.
`ifdef OBSTACLE_OUTLINE_EN
    wren_n = (state_n == FILL) &&
             (!lout || cx_n == xl || cx_n == xh || cy_n == yl || cy_n == yh);
`else
    wren_n = (state_n == FILL);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      wren  <= 1'b0;
      cx    <= '0;
      cy    <= '0;
      lx0   <= '0;
      lx1   <= '0;
      ly0   <= '0;
      ly1   <= '0;
      lcol  <= '0;
`ifdef OBSTACLE_OUTLINE_EN
      lout  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
      wren  <= wren_n;
      cx    <= cx_n;
      cy    <= cy_n;
      if (accept) begin
        lx0  <= x0;
        lx1  <= x1;
        ly0  <= y0;
        ly1  <= y1;
        lcol <= color;
`ifdef OBSTACLE_OUTLINE_EN
        lout <= outline;
`endif
      end
    end
  end

  assign x_write  = cx;
  assign y_write  = cy;
  assign color_in = lcol;

endmodule

// File: tb/tb_obstacle_painter.sv
// Directed plus randomized bench for obstacle_painter against a set-based rectangle model.
module tb_obstacle_painter;
  logic       clk = 1'b0, resetn = 1'b1, start = 1'b0, outline = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] color = '0;
  logic       busy, done, wren;
  logic [7:0] x_write;
  logic [6:0] y_write;
  logic [2:0] color_in;

  int compared = 0, mismatched = 0;
  logic [17:0] exp_q[$];
  int exp_fill, exp_done;

  obstacle_painter dut (
    .clk(clk), .resetn(resetn), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .outline(outline),
    .busy(busy), .done(done), .x_write(x_write), .y_write(y_write),
    .color_in(color_in), .wren(wren)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write list: every in-bounds pixel of the clipped rectangle, row-major.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1,
                             input int acol, input bit aout);
    int xl, xh, yl, yh;
    bit wr;
    exp_q.delete();
    xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
    if (xh > 159) xh = 159;
    if (yh > 119) yh = 119;
    exp_fill = 0;
    if (xl <= 159 && yl <= 119) begin
      exp_fill = (xh - xl + 1) * (yh - yl + 1);
      for (int y = yl; y <= yh; y++)
        for (int x = xl; x <= xh; x++) begin
          wr = 1'b1;
`ifdef OBSTACLE_OUTLINE_EN
          wr = !aout || x == xl || x == xh || y == yl || y == yh;
`else
          if (aout) wr = 1'b1;
`endif
          if (wr) exp_q.push_back({8'(x), 7'(y), 3'(acol)});
        end
    end
    exp_done = (exp_fill == 0) ? 2 : exp_fill + 2;
  endtask

  task automatic run_req(input logic [7:0] ax0, input logic [6:0] ay0,
                         input logic [7:0] ax1, input logic [6:0] ay1,
                         input logic [2:0] acol, input logic aout, input int inj);
    int cyc, first, limit;
    bit got_done;
    logic [17:0] e;
    build_model(int'(ax0), int'(ay0), int'(ax1), int'(ay1), int'(acol), aout);
    @(negedge clk);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = acol; outline = aout; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = 8'($urandom); x1 = 8'($urandom); y0 = 7'($urandom); y1 = 7'($urandom);
    color = 3'($urandom); outline = 1'($urandom);
    cyc = 1; first = -1; got_done = 0; limit = exp_done + 20;
    while (!got_done && cyc <= limit) begin
      check("busy_high", 32'(busy), 32'd1);
      if (wren) begin
        if (first < 0) first = cyc;
        check("wren_window", 32'(cyc >= 2 && cyc <= exp_fill + 1), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("pixel", 32'({x_write, y_write, color_in}), 32'(e));
      end
      if (done) begin
        got_done = 1;
        check("done_cycle", 32'(cyc), 32'(exp_done));
      end else begin
        @(negedge clk);
        cyc++;
        start = (cyc == inj);
        if (start) begin
          x0 = 8'($urandom); x1 = 8'($urandom); y0 = 7'($urandom); y1 = 7'($urandom);
        end
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    if (exp_fill > 0) check("first_wren", 32'(first), 32'd2);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n, t, xa, xb, ya, yb, d;
    #2 resetn = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_addr", 32'({x_write, y_write, color_in}), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_req(8'd10, 7'd20, 8'd11, 7'd21, 3'b010, 1'b0, 0);   // basic 2x2
    run_req(8'd50, 7'd5, 8'd48, 7'd5, 3'b101, 1'b0, 0);     // swapped corners
    run_req(8'd158, 7'd118, 8'd200, 7'd127, 3'b111, 1'b0, 0); // clipped
    run_req(8'd170, 7'd3, 8'd170, 7'd9, 3'b001, 1'b0, 0);   // empty
    run_req(8'd0, 7'd0, 8'd3, 7'd2, 3'b110, 1'b1, 0);       // 4x3 outline
    run_req(8'd0, 7'd0, 8'd3, 7'd2, 3'b110, 1'b0, 0);
    run_req(8'd30, 7'd30, 8'd33, 7'd32, 3'b011, 1'b0, 4);   // start during FILL
    run_req(8'd60, 7'd60, 8'd60, 7'd60, 3'b100, 1'b0, 3);   // start coincident with done

    // Reset in the middle of a 3x3 fill
    @(negedge clk);
    x0 = 8'd5; y0 = 7'd5; x1 = 8'd7; y1 = 7'd7; color = 3'b111; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 0; t = 0;
    while (n < 3 && t < 20) begin
      @(negedge clk);
      t++;
      if (wren) n++;
    end
    check("rst_reach_write3", 32'(n), 32'd3);
    resetn = 1'b0;
    #1;
    check("rst_mid_wren", 32'(wren), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'({x_write, y_write, color_in}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'({done, busy, wren}), 32'd0);
    end
    run_req(8'd9, 7'd9, 8'd9, 7'd9, 3'b010, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      xa = $urandom_range(255, 0); d = $urandom_range(9, 0);
      xb = (xa + d > 255) ? xa - d : xa + d;
      ya = $urandom_range(127, 0); d = $urandom_range(6, 0);
      yb = (ya + d > 127) ? ya - d : ya + d;
      if ($urandom_range(1, 0) == 1) run_req(8'(xb), 7'(yb), 8'(xa), 7'(ya), 3'($urandom), 1'($urandom), 0);
      else run_req(8'(xa), 7'(ya), 8'(xb), 7'(yb), 3'($urandom), 1'($urandom), $urandom_range(6, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
